// File: rtl/sram_arbiter_if.sv
// Requester-side handshake bundle for sram_arbiter: a read port (display fetch)
// and a write port (pixel engine), each a req/gnt pair.
interface sram_arbiter_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
);
   // Handshake: a requester raises req with addr (and data for writes) and holds
   // them until gnt pulses; it may drop or change them in the gnt cycle. A req
   // still high after gnt counts as a fresh request. rd_valid pulses once with
   // rd_data for each granted read.
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_gnt;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_gnt;

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data,
      input  rd_gnt, rd_data, rd_valid, wr_gnt
   );

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
      output rd_gnt, rd_data, rd_valid, wr_gnt
   );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter owning an asynchronous 16-bit SRAM; reads have priority.
// Define SRAM_ARB_STARVE_GUARD_EN to force a write after STARVE_LIMIT reads.
module sram_arbiter #(
   parameter int ADDR_W       = 20,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   sram_arbiter_if.slave                       req_if,
   output logic [ADDR_W-1:0]                   sram_addr,
   inout  wire  [DATA_W-1:0]                   sram_dq,
   output logic                                ce_n,
   output logic                                ub_n,
   output logic                                lb_n,
   output logic                                oe_n,
   output logic                                we_n,
   output logic                                busy,
   output logic [2:0]                          dbg_state_o,
   output logic [$clog2(STARVE_LIMIT+1)-1:0]   dbg_starve_o
);
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD1  = 3'd1,
      RD2  = 3'd2,
      WR1  = 3'd3,
      WR2  = 3'd4
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              drive_q;
   logic              oe_n_q;
   logic              we_n_q;
   logic              rd_gnt_q;
   logic              wr_gnt_q;
   logic              rd_valid_q;
   logic              busy_q;
   logic              rd_wins;

`ifdef SRAM_ARB_STARVE_GUARD_EN
   logic [STARVE_W-1:0] starve_q;

   // Once the writer has watched STARVE_LIMIT reads go by, it takes the next slot.
   assign rd_wins = req_if.rd_req &&
                    !(req_if.wr_req && (starve_q == STARVE_W'(STARVE_LIMIT)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_q <= '0;
      end else if (state_q == IDLE) begin
         if (!req_if.wr_req)
            starve_q <= '0;
         else if (rd_wins)
            starve_q <= starve_q + 1'b1;
         else
            starve_q <= '0;
      end
   end

   assign dbg_starve_o = starve_q;
`else
   assign rd_wins      = req_if.rd_req;
   assign dbg_starve_o = '0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         drive_q    <= 1'b0;
         oe_n_q     <= 1'b1;
         we_n_q     <= 1'b1;
         rd_gnt_q   <= 1'b0;
         wr_gnt_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         rd_gnt_q   <= 1'b0;
         wr_gnt_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rd_wins) begin
                  addr_q   <= req_if.rd_addr;
                  oe_n_q   <= 1'b0;
                  rd_gnt_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= RD1;
               end else if (req_if.wr_req) begin
                  addr_q   <= req_if.wr_addr;
                  wdata_q  <= req_if.wr_data;
                  we_n_q   <= 1'b0;
                  drive_q  <= 1'b1;
                  wr_gnt_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= WR1;
               end
            end
            RD1: state_q <= RD2;
            RD2: begin
               rdata_q    <= sram_dq;
               rd_valid_q <= 1'b1;
               oe_n_q     <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
            // Data keeps driving one cycle past the we_n rising edge for hold time.
            WR1: begin
               we_n_q  <= 1'b1;
               state_q <= WR2;
            end
            WR2: begin
               drive_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               oe_n_q  <= 1'b1;
               we_n_q  <= 1'b1;
               drive_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign sram_dq         = drive_q ? wdata_q : {DATA_W{1'bz}};
   assign sram_addr       = addr_q;
   assign ce_n            = 1'b0;
   assign ub_n            = 1'b0;
   assign lb_n            = 1'b0;
   assign oe_n            = oe_n_q;
   assign we_n            = we_n_q;
   assign busy            = busy_q;
   assign dbg_state_o     = state_q;
   assign req_if.rd_gnt   = rd_gnt_q;
   assign req_if.wr_gnt   = wr_gnt_q;
   assign req_if.rd_data  = rdata_q;
   assign req_if.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small asynchronous SRAM model on the pins.
// The starvation section follows SRAM_ARB_STARVE_GUARD_EN as the DUT does.
module tb_sram_arbiter;
   localparam int ADDR_W = 20;
   localparam int DATA_W = 16;

   logic              clk;
   logic              rst;
   logic [ADDR_W-1:0] sram_addr;
   wire  [DATA_W-1:0] sram_dq;
   logic              ce_n, ub_n, lb_n, oe_n, we_n, busy;
   logic [2:0]        dbg_state;
   logic [3:0]        dbg_starve;

   logic [DATA_W-1:0] mem [0:255];
   logic [DATA_W-1:0] model_dq;
   logic              probe_en;

   int n_checks;
   int n_pass;
   logic [DATA_W-1:0] exp_q[$];

   sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

   sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_if       (bus_if.slave),
      .sram_addr    (sram_addr),
      .sram_dq      (sram_dq),
      .ce_n         (ce_n),
      .ub_n         (ub_n),
      .lb_n         (lb_n),
      .oe_n         (oe_n),
      .we_n         (we_n),
      .busy         (busy),
      .dbg_state_o  (dbg_state),
      .dbg_starve_o (dbg_starve)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: drives on oe_n low; probe_en pulls the bus to zero so an idle
   // DUT driver shows up as a nonzero value.
   always_comb begin
      model_dq = '0;
      if (!oe_n) model_dq = mem[sram_addr[7:0]];
   end
   assign sram_dq = (!oe_n || probe_en) ? model_dq : {DATA_W{1'bz}};

   always @(posedge we_n) begin
      if (rst) mem[sram_addr[7:0]] = sram_dq;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [19:0] a, input logic [15:0] d, input string tag);
      int n;
      bus_if.wr_req  = 1'b1;
      bus_if.wr_addr = a;
      bus_if.wr_data = d;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus_if.wr_gnt && n < 10);
      chk({tag, "_gnt"}, 32'(bus_if.wr_gnt), 32'd1);
      bus_if.wr_req = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (busy && n < 10);
      chk({tag, "_done"}, 32'(busy), 32'd0);
   endtask

   task automatic do_read(input logic [19:0] a, input logic [15:0] d, input string tag);
      int n;
      logic [DATA_W-1:0] e;
      exp_q.push_back(d);
      bus_if.rd_req  = 1'b1;
      bus_if.rd_addr = a;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus_if.rd_gnt && n < 10);
      chk({tag, "_gnt"}, 32'(bus_if.rd_gnt), 32'd1);
      chk({tag, "_addr"}, 32'(sram_addr), 32'(a));
      bus_if.rd_req = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus_if.rd_valid && n < 10);
      chk({tag, "_valid"}, 32'(bus_if.rd_valid), 32'd1);
      e = exp_q.pop_front();
      chk({tag, "_data"}, 32'(bus_if.rd_data), 32'(e));
   endtask

   initial begin
      int rd_cnt;
      int wr_cnt;
      int rd_after;
      n_checks = 0;
      n_pass   = 0;
      probe_en = 1'b1;
      mem[8'h10] = 16'hC3C3;
      rst = 1'b0;
      bus_if.rd_req = 1'b0; bus_if.wr_req = 1'b0;
      bus_if.rd_addr = '0; bus_if.wr_addr = '0; bus_if.wr_data = '0;

      // reset with random inputs
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus_if.rd_req  = 1'($urandom_range(0, 1));
         bus_if.wr_req  = 1'($urandom_range(0, 1));
         bus_if.rd_addr = 20'($urandom_range(0, 20'hFFFFF));
         bus_if.wr_addr = 20'($urandom_range(0, 20'hFFFFF));
         bus_if.wr_data = 16'($urandom_range(0, 16'hFFFF));
      end
      @(negedge clk);
      chk("rst_oe_n", 32'(oe_n), 32'd1);
      chk("rst_we_n", 32'(we_n), 32'd1);
      chk("rst_dq_z", 32'(sram_dq), 32'd0);
      chk("rst_rd_gnt", 32'(bus_if.rd_gnt), 32'd0);
      chk("rst_wr_gnt", 32'(bus_if.wr_gnt), 32'd0);
      chk("rst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_strobes", 32'({ce_n, ub_n, lb_n}), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
      bus_if.rd_req = 1'b0; bus_if.wr_req = 1'b0;
      probe_en = 1'b0;
      rst = 1'b1;

      // single write 0x12345 <- 0xBEEF
      bus_if.wr_req = 1'b1; bus_if.wr_addr = 20'h12345; bus_if.wr_data = 16'hBEEF;
      tick();
      bus_if.wr_req = 1'b0;
      @(negedge clk);
      chk("wr1_gnt", 32'(bus_if.wr_gnt), 32'd1);
      chk("wr1_we_n", 32'(we_n), 32'd0);
      chk("wr1_addr", 32'(sram_addr), 32'h12345);
      chk("wr1_dq", 32'(sram_dq), 32'hBEEF);
      chk("wr1_busy", 32'(busy), 32'd1);
      tick();
      @(negedge clk);
      chk("wr2_gnt", 32'(bus_if.wr_gnt), 32'd0);
      chk("wr2_we_n", 32'(we_n), 32'd1);
      chk("wr2_dq_hold", 32'(sram_dq), 32'hBEEF);
      chk("wr2_busy", 32'(busy), 32'd1);
      tick();
      probe_en = 1'b1;
      @(negedge clk);
      chk("wr_end_dq_z", 32'(sram_dq), 32'd0);
      chk("wr_end_busy", 32'(busy), 32'd0);
      probe_en = 1'b0;

      // read back 0x12345, cycle by cycle
      bus_if.rd_req = 1'b1; bus_if.rd_addr = 20'h12345;
      tick();
      bus_if.rd_req = 1'b0;
      @(negedge clk);
      chk("rd1_gnt", 32'(bus_if.rd_gnt), 32'd1);
      chk("rd1_oe_n", 32'(oe_n), 32'd0);
      chk("rd1_we_n", 32'(we_n), 32'd1);
      chk("rd1_addr", 32'(sram_addr), 32'h12345);
      tick();
      @(negedge clk);
      chk("rd2_gnt", 32'(bus_if.rd_gnt), 32'd0);
      chk("rd2_oe_n", 32'(oe_n), 32'd0);
      chk("rd2_valid", 32'(bus_if.rd_valid), 32'd0);
      tick();
      @(negedge clk);
      chk("rd_valid", 32'(bus_if.rd_valid), 32'd1);
      chk("rd_data", 32'(bus_if.rd_data), 32'hBEEF);
      chk("rd_oe_off", 32'(oe_n), 32'd1);
      chk("rd_busy", 32'(busy), 32'd0);
      tick();
      @(negedge clk);
      chk("rd_valid_pulse", 32'(bus_if.rd_valid), 32'd0);

      // collision: read 0x10 wins, write 0x20 follows after one IDLE gap
      bus_if.rd_req = 1'b1; bus_if.rd_addr = 20'h00010;
      bus_if.wr_req = 1'b1; bus_if.wr_addr = 20'h00020; bus_if.wr_data = 16'h5A5A;
      tick();
      bus_if.rd_req = 1'b0;
      @(negedge clk);
      chk("col_rd_gnt", 32'(bus_if.rd_gnt), 32'd1);
      chk("col_no_wr_gnt", 32'(bus_if.wr_gnt), 32'd0);
      chk("col_rd_addr", 32'(sram_addr), 32'h00010);
      tick();
      tick();
      probe_en = 1'b1;
      @(negedge clk);
      chk("col_rd_data", 32'(bus_if.rd_data), 32'hC3C3);
      chk("col_gap_oe_n", 32'(oe_n), 32'd1);
      chk("col_gap_dq_z", 32'(sram_dq), 32'd0);
      chk("col_gap_idle", 32'(dbg_state), 32'd0);
      tick();
      probe_en = 1'b0;
      bus_if.wr_req = 1'b0;
      @(negedge clk);
      chk("col_wr_gnt", 32'(bus_if.wr_gnt), 32'd1);
      chk("col_wr_addr", 32'(sram_addr), 32'h00020);
      chk("col_wr_dq", 32'(sram_dq), 32'h5A5A);
      tick();
      tick();
      @(negedge clk);
      do_read(20'h00020, 16'h5A5A, "col_readback");

      // top of the address range passes through unmodified
      do_write(20'hFFFFF, 16'h0F0F, "top_wr");
      do_read(20'hFFFFF, 16'h0F0F, "top_rd");

      // both requests held high
      rd_cnt = 0; wr_cnt = 0; rd_after = 0;
      bus_if.rd_req = 1'b1; bus_if.rd_addr = 20'h00030;
      bus_if.wr_req = 1'b1; bus_if.wr_addr = 20'h00031; bus_if.wr_data = 16'h7777;
`ifdef SRAM_ARB_STARVE_GUARD_EN
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus_if.wr_gnt) wr_cnt++;
         if (bus_if.rd_gnt) begin
            if (wr_cnt == 0) rd_cnt++;
            else rd_after++;
         end
      end
      chk("starve_reads_first", 32'(rd_cnt), 32'd8);
      chk("starve_one_write", 32'(wr_cnt), 32'd1);
      chk("starve_reads_resume", 32'(rd_after > 0), 32'd1);
`else
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus_if.wr_gnt) wr_cnt++;
         if (bus_if.rd_gnt) rd_cnt++;
      end
      chk("strict_no_write", 32'(wr_cnt), 32'd0);
      chk("strict_reads", 32'(rd_cnt >= 30), 32'd1);
`endif
      bus_if.rd_req = 1'b0; bus_if.wr_req = 1'b0;
      repeat (4) @(negedge clk);
      chk("hold_end_idle", 32'(dbg_state), 32'd0);

      // reset in the middle of WR1
      bus_if.wr_req = 1'b1; bus_if.wr_addr = 20'h00040; bus_if.wr_data = 16'h1234;
      tick();
      bus_if.wr_req = 1'b0;
      #1;
      chk("mid_pre_we_n", 32'(we_n), 32'd0);
      rst = 1'b0;
      probe_en = 1'b1;
      #1;
      chk("mid_we_n", 32'(we_n), 32'd1);
      chk("mid_oe_n", 32'(oe_n), 32'd1);
      chk("mid_dq_z", 32'(sram_dq), 32'd0);
      chk("mid_wr_gnt", 32'(bus_if.wr_gnt), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      probe_en = 1'b0;
      tick();
      @(negedge clk);
      chk("post_rst_state", 32'(dbg_state), 32'd0);
      chk("post_rst_wr_gnt", 32'(bus_if.wr_gnt), 32'd0);
      do_read(20'h12345, 16'hBEEF, "post_rst_rd");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sole owner of the external asynchronous 16-bit SRAM pins; shares the SRAM between two requesters.
  - Write port: the Julia pixel compute engine storing iteration results.
  - Read port: the display fetch logic.
- Sequences each access as a fixed multi-cycle SRAM cycle with proper bus turnaround.
- Read port has priority; an optional starvation guard protects the writer.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 16, SRAM data width.
- STARVE_LIMIT, 8, consecutive read grants tolerated while a write waits (guard feature only).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- rd_req  input  1  read request; held with rd_addr until rd_gnt.
- rd_addr  input  ADDR_W  read word address.
- rd_gnt  output  1  one-cycle pulse: read accepted.
- rd_data  output  DATA_W  read result, valid while rd_valid.
- rd_valid  output  1  one-cycle pulse: rd_data valid.
- wr_req  input  1  write request; held with wr_addr/wr_data until wr_gnt.
- wr_addr  input  ADDR_W  write word address.
- wr_data  input  DATA_W  write data.
- wr_gnt  output  1  one-cycle pulse: write accepted.
- sram_addr  output  ADDR_W  SRAM address.
- sram_dq  inout  DATA_W  SRAM data bus.
- ce_n, ub_n, lb_n  output  1 each  tied 0: chip always selected, both bytes enabled.
- oe_n  output  1  SRAM output enable, active low.
- we_n  output  1  SRAM write enable, active low.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset is asynchronous and active low. While rst=0:
  - state=IDLE; sram_addr=0.
  - oe_n=1, we_n=1, dq drive enable=0 (bus Z).
  - rd_gnt=0, wr_gnt=0, rd_valid=0, rd_data=0, starve counter=0.
- All outputs are registered except ce_n/ub_n/lb_n (constants) and sram_dq.
  - sram_dq = drive_en ? data register : Z.
  - drive_en is a state register; it is never derived combinationally from we_n.
- FSM states: IDLE, RD1, RD2, WR1, WR2.
- IDLE, arbitration at each edge:
  - rd_req=1 → latch rd_addr into sram_addr; go to RD1; rd_gnt=1 for the next cycle.
  - else wr_req=1 → latch wr_addr and wr_data; go to WR1; wr_gnt=1 for the next cycle.
  - else stay in IDLE.
  - Both requests high → read wins (modified by the optional feature).
- RD1: oe_n=0, we_n=1, bus Z. Go to RD2.
- RD2: oe_n=0. At the RD2→IDLE edge, capture sram_dq into rd_data; rd_valid=1 for the following cycle; oe_n returns to 1.
- Read latency: rd_req sampled at edge E0 → rd_gnt during cycle E0..E1 → rd_valid during cycle E2..E3.
- WR1: we_n=0, drive_en=1, sram_addr and data stable. Go to WR2.
- WR2: we_n=1, drive_en stays 1 (data hold after the we_n rising edge), sram_addr unchanged. Go to IDLE; drive_en=0 on entry to IDLE.
- Throughput: one access per 3 cycles (two access cycles + one IDLE arbitration cycle).
  - The IDLE cycle is the mandatory bus-turnaround gap.
  - oe_n=0 and drive_en=1 are never active in the same cycle.
- Handshake:
  - A requester deasserts or updates req/addr/data in the cycle its gnt is high.
  - A req still high after gnt is treated as a new request at the next IDLE.
  - rd_req/wr_req/addresses/data are sampled only in IDLE; they are don't-care elsewhere.
- sram_addr holds its last value in IDLE, so there are no address glitches.
- Reset mid-access: immediate IDLE, we_n=1, oe_n=1, bus Z. The in-flight access is abandoned; no rd_valid/wr_gnt is produced for it.
- Address wrap: none internally; addresses pass through unmodified (0xFFFFF is legal).

Optional Feature:
- Macro: SRAM_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter (width ≥ clog2(STARVE_LIMIT+1)) increments on each read grant made while wr_req=1.
  - It clears on any write grant or whenever wr_req=0 in IDLE.
  - When count == STARVE_LIMIT, the next IDLE arbitration grants the write even if rd_req=1.
- Undefined:
  - Strict read priority; the writer can starve indefinitely; no counter logic is present.

Test Plan:
- Reset: hold rst=0 with random inputs → oe_n=1, we_n=1, sram_dq=Z, rd_gnt/wr_gnt/rd_valid/busy=0, sram_addr=0x00000, ce_n/ub_n/lb_n=0.
- Single write: wr_req with addr 0x12345, data 0xBEEF → wr_gnt for one cycle; we_n=0 for exactly one cycle with sram_addr=0x12345 and dq=0xBEEF; dq still 0xBEEF in the cycle after we_n rises; Z afterwards; busy high for 2 cycles.
- Read back via SRAM model: rd_req addr 0x12345 → rd_gnt, oe_n=0 for 2 cycles, rd_valid in the 3rd cycle after sampling with rd_data=0xBEEF; dq never driven by the DUT.
- Collision: rd_req and wr_req together (0x00010 / 0x00020, data 0x5A5A) → read of 0x00010 first; write of 0x00020 granted at the next IDLE; one IDLE gap between oe_n deassert and drive_en assert.
- Starvation (macro defined, STARVE_LIMIT=8): rd_req and wr_req both held high → exactly 8 read grants, then 1 write grant, then reads resume. Macro undefined → zero write grants over 100 cycles.
- Reset during WR1 → we_n=1 and sram_dq=Z asynchronously before the next clock edge; no wr_gnt; FSM in IDLE after release.
